sreg_word_fifo: RTL and testbench

Synchronous FIFO that buffers the 4-bit words produced by the shift-register stage. Its `sout` output feeds `wr_data`, and the register's per-clock shift enable feeds `wr_en`. Consumers drain the words at their own rate through a registered read port, so a bursty shift pipeline is decoupled from a slower downstream stage. Overflow and underflow are reported with sticky error flags.

---
 rtl/sreg_pkg.sv | 9 +
 rtl/fifo_ptr.sv | 33 +++
 rtl/sreg_word_fifo.sv | 106 ++++++++++
 tb/tb_sreg_word_fifo.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/sreg_pkg.sv
// Shared constants and word type for the shift-register stage and its output FIFO.
package sreg_pkg;

  localparam int SREG_WIDTH      = 4;
  localparam int SREG_FIFO_DEPTH = 8;

  typedef logic [SREG_WIDTH-1:0] sreg_word_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: AW address bits plus one wrap bit, advanced by inc.
module fifo_ptr #(
  parameter int AW = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [AW:0] ptr
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] ptr_q;
  logic [AW:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      ptr_d = ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sreg_word_fifo.sv
// Synchronous word FIFO behind the shift register, with registered read and sticky error flags.
// Optional occupancy output `count` is built when SREG_WORD_FIFO_COUNT_EN is defined.
module sreg_word_fifo
  import sreg_pkg::*;
#(
  parameter int WIDTH = SREG_WIDTH,
  parameter int DEPTH = SREG_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
`ifdef SREG_WORD_FIFO_COUNT_EN
  ,
  output logic [AW:0]      count
`endif
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        wr_acc;
  logic        rd_acc;

  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  // Flags decode only registered pointers, so no input reaches them combinationally.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_acc),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (wr_acc && !reset) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_acc;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (rd_acc) begin
      rd_data_d = mem[rd_ptr[AW-1:0]];
    end
    if (wr_en && !wr_acc) begin
      overflow_d = 1'b1;
    end
    if (rd_en && !rd_acc) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef SREG_WORD_FIFO_COUNT_EN
  assign count = wr_ptr - rd_ptr;
`endif

endmodule

// File: tb/tb_sreg_word_fifo.sv
// Directed plus randomized bench for sreg_word_fifo against a queue-based occupancy model.
module tb_sreg_word_fifo;
  import sreg_pkg::*;

  localparam int DEPTH = SREG_FIFO_DEPTH;
  localparam int AW    = $clog2(DEPTH);

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic       rd_en;
  sreg_word_t wr_data;
  sreg_word_t rd_data;
  logic       full, empty, rd_valid, overflow, underflow;
`ifdef SREG_WORD_FIFO_COUNT_EN
  logic [AW:0] count;
`endif

  always #5 clk = ~clk;

  sreg_word_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef SREG_WORD_FIFO_COUNT_EN
    ,
    .count     (count)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: contents as a queue, plus the visible registered outputs.
  sreg_word_t q[$];
  sreg_word_t m_rd_data;
  bit         m_rd_valid;
  bit         m_ovf;
  bit         m_unf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit rst, input bit wr, input sreg_word_t wd, input bit rd);
    bit rd_ok;
    bit wr_ok;
    reset   = rst;
    wr_en   = wr;
    wr_data = wd;
    rd_en   = rd;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
      m_unf      = 1'b0;
    end else begin
      rd_ok = rd && (q.size() > 0);
      wr_ok = wr && ((q.size() < DEPTH) || rd_ok);
      m_rd_valid = rd_ok;
      if (rd_ok) m_rd_data = q.pop_front();
      if (wr_ok) q.push_back(wd);
      if (wr && !wr_ok) m_ovf = 1'b1;
      if (rd && !rd_ok) m_unf = 1'b1;
    end
    #1;
    check_eq("empty", {31'b0, empty}, {31'b0, q.size() == 0});
    check_eq("full", {31'b0, full}, {31'b0, q.size() == DEPTH});
    check_eq("rd_valid", {31'b0, rd_valid}, {31'b0, m_rd_valid});
    check_eq("rd_data", {28'b0, rd_data}, {28'b0, m_rd_data});
    check_eq("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    check_eq("underflow", {31'b0, underflow}, {31'b0, m_unf});
`ifdef SREG_WORD_FIFO_COUNT_EN
    check_eq("count", {{(31-AW){1'b0}}, count}, q.size());
`endif
    $display("cyc %0d rst=%0b wr=%0b wd=%h rd=%0b -> rd_data=%h rd_valid=%0b empty=%0b full=%0b ovf=%0b unf=%0b occ=%0d",
             cyc, rst, wr, wd, rd, rd_data, rd_valid, empty, full, overflow, underflow, q.size());
  endtask

  initial begin
    int pw_tab[4];
    int pr_tab[4];
    pw_tab = '{80, 20, 50, 95};
    pr_tab = '{20, 80, 50, 95};
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;

    // 1: reset for two cycles
    step(1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 1'b0);

    // 2: fill 1..8 then drain in order
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, sreg_word_t'(i), 1'b0);
    check_eq("t2_full", {31'b0, full}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 4'h0, 1'b1);
      check_eq("t2_order", {28'b0, rd_data}, i);
    end
    check_eq("t2_empty", {31'b0, empty}, 32'd1);

    // 3: overflow drops the extra word
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, sreg_word_t'(i), 1'b0);
    step(1'b0, 1'b1, 4'hA, 1'b0);
    check_eq("t3_ovf", {31'b0, overflow}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 4'h0, 1'b1);
      check_eq("t3_order", {28'b0, rd_data}, i);
    end

    // 4: simultaneous read and write while full
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, sreg_word_t'(i), 1'b0);
    step(1'b0, 1'b1, 4'h9, 1'b1);
    check_eq("t4_rd", {28'b0, rd_data}, 32'd1);
    check_eq("t4_full", {31'b0, full}, 32'd1);
    for (int i = 2; i <= 9; i++) begin
      step(1'b0, 1'b0, 4'h0, 1'b1);
      check_eq("t4_order", {28'b0, rd_data}, i);
    end

    // 5: underflow, then read and write together on empty
    step(1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    check_eq("t5_unf", {31'b0, underflow}, 32'd1);
    step(1'b0, 1'b1, 4'h5, 1'b1);
    check_eq("t5_nofall", {31'b0, rd_valid}, 32'd0);
    check_eq("t5_notempty", {31'b0, empty}, 32'd0);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    check_eq("t5_data", {28'b0, rd_data}, 32'h5);

    // 6: reset mid-operation discards contents
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, sreg_word_t'(4'hC + i), 1'b0);
    step(1'b1, 1'b1, 4'hF, 1'b1);
    check_eq("t6_empty", {31'b0, empty}, 32'd1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    check_eq("t6_noread", {31'b0, rd_valid}, 32'd0);

    // Randomized phases with differing write/read pressure
    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 100; n++) begin
        step($urandom_range(99) == 0,
             $urandom_range(99) < pw_tab[ph],
             sreg_word_t'($urandom_range(15)),
             $urandom_range(99) < pr_tab[ph]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
